vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator, successor to the fixed 640x480 driver.
- Produces sync, data-enable and next-pixel coordinates, plus a linear frame-buffer read address with power-of-two pixel replication, e.g. a 160x120 camera buffer upscaled to 640x480.
- Delays the sync, DE and colour outputs to match a configurable frame-buffer read latency.
- Sits between the camera frame buffer (read port) and the VGA pins.

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_delay_line.sv | 42 ++++
 rtl/vga_timing_gen.sv | 152 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing presets, helper functions and the decoded control bundle for the VGA raster generator.
package vga_timing_pkg;

    localparam int COLOR_W_DEF = 12;

    // 640x480@60, 25.175 MHz pixel clock
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 800x600@60, 40 MHz pixel clock
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic fs;
        logic ls;
    } vga_ctl_t;

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int vga_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register aligning timing flags with frame-buffer read latency.
// DEPTH=0 collapses to a wire; stages clear to all-zero (blank) on reset.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = ^{clk, rst, en};
        assign dout      = din;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else if (en) begin
                stage_q <= stage_d;
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: fetch-stage counters and scaled buffer address,
// with sync/DE/colour delayed by PIX_LAT+1 cycles to meet the frame-buffer read data.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = VGA640_H_ACTIVE,
    parameter int H_FP        = VGA640_H_FP,
    parameter int H_SYNC      = VGA640_H_SYNC,
    parameter int H_BP        = VGA640_H_BP,
    parameter int V_ACTIVE    = VGA640_V_ACTIVE,
    parameter int V_FP        = VGA640_V_FP,
    parameter int V_SYNC      = VGA640_V_SYNC,
    parameter int V_BP        = VGA640_V_BP,
    parameter int HSYNC_POL   = 0,
    parameter int VSYNC_POL   = 0,
    parameter int COLOR_W     = COLOR_W_DEF,
    parameter int SCALE_SHIFT = 0,
    parameter int PIX_LAT     = 1,
    localparam int H_TOTAL    = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL    = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW         = vga_width(H_TOTAL),
    localparam int VW         = vga_width(V_TOTAL),
    localparam int AW         = vga_width((H_ACTIVE >> SCALE_SHIFT) * (V_ACTIVE >> SCALE_SHIFT))
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [COLOR_W-1:0] pixel_in,
    output logic [HW-1:0]      posX,
    output logic [VW-1:0]      posY,
    output logic               fetch_valid,
    output logic [AW-1:0]      buf_addr,
    output logic [COLOR_W-1:0] pixel_out,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_start,
    output logic               line_start
);

    if ((H_ACTIVE % (1 << SCALE_SHIFT)) != 0 || (V_ACTIVE % (1 << SCALE_SHIFT)) != 0 ||
        H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        PIX_LAT < 0 || PIX_LAT > 4) begin : g_bad_params
        $error("vga_timing_gen: illegal timing parameters");
    end

    localparam logic [HW-1:0] X_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] X_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] Y_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] Y_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] Y_MASK   = VW'((1 << SCALE_SHIFT) - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(H_ACTIVE >> SCALE_SHIFT);
    localparam logic          HS_ON    = 1'(HSYNC_POL);
    localparam logic          VS_ON    = 1'(VSYNC_POL);

    logic [HW-1:0]      pos_x_q, pos_x_d;
    logic [VW-1:0]      pos_y_q, pos_y_d;
    logic [AW-1:0]      row_base_q, row_base_d;
    logic               x_wrap, y_wrap;
    vga_ctl_t           ctl_fetch, ctl_dly;
    logic [COLOR_W-1:0] pixel_q, pixel_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic               fs_q, fs_d;
    logic               ls_q, ls_d;

    // row_base advances on the last replicated line of each source row.
    always_comb begin
        x_wrap     = (pos_x_q == X_LAST);
        y_wrap     = (pos_y_q == Y_LAST);
        pos_x_d    = x_wrap ? '0 : pos_x_q + 1'b1;
        pos_y_d    = pos_y_q;
        row_base_d = row_base_q;
        if (x_wrap) begin
            pos_y_d = y_wrap ? '0 : pos_y_q + 1'b1;
            if (y_wrap) begin
                row_base_d = '0;
            end else if (pos_y_q < Y_ACT && (pos_y_q & Y_MASK) == Y_MASK) begin
                row_base_d = row_base_q + ROW_STEP;
            end
        end
    end

    always_comb begin
        fetch_valid   = (pos_x_q < X_ACT) && (pos_y_q < Y_ACT);
        ctl_fetch.act = fetch_valid;
        ctl_fetch.hs  = (pos_x_q >= HS_BEG) && (pos_x_q < HS_END);
        ctl_fetch.vs  = (pos_y_q >= VS_BEG) && (pos_y_q < VS_END);
        ctl_fetch.fs  = (pos_x_q == '0) && (pos_y_q == '0);
        ctl_fetch.ls  = (pos_x_q == '0) && (pos_y_q < Y_ACT);
        buf_addr      = fetch_valid ? row_base_q + AW'(pos_x_q >> SCALE_SHIFT) : '0;
    end

    vga_delay_line #(
        .WIDTH ($bits(vga_ctl_t)),
        .DEPTH (PIX_LAT)
    ) u_ctl_dly (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (ctl_fetch),
        .dout (ctl_dly)
    );

    always_comb begin
        pixel_d = ctl_dly.act ? pixel_in : '0;
        hsync_d = ctl_dly.hs ? HS_ON : ~HS_ON;
        vsync_d = ctl_dly.vs ? VS_ON : ~VS_ON;
        de_d    = ctl_dly.act;
        fs_d    = ctl_dly.fs;
        ls_d    = ctl_dly.ls;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            row_base_q <= '0;
            pixel_q    <= '0;
            hsync_q    <= ~HS_ON;
            vsync_q    <= ~VS_ON;
            de_q       <= 1'b0;
            fs_q       <= 1'b0;
            ls_q       <= 1'b0;
        end else if (en) begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            row_base_q <= row_base_d;
            pixel_q    <= pixel_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_d;
            fs_q       <= fs_d;
            ls_q       <= ls_d;
        end
    end

    assign posX        = pos_x_q;
    assign posY        = pos_y_q;
    assign pixel_out   = pixel_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance, a 4x-scaled instance with PIX_LAT=2, and a tiny positive-sync instance with PIX_LAT=0.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    always #5 clk = ~clk;

    // default instance
    logic [9:0]  vga_x, vga_y;
    logic [18:0] vga_addr;
    logic [11:0] vga_pix, vga_out;
    logic        vga_fv, vga_hs, vga_vs, vga_de, vga_fs, vga_ls;

    // 160x120 buffer upscaled 4x, PIX_LAT=2
    logic [9:0]  scl_x, scl_y;
    logic [14:0] scl_addr;
    logic [11:0] scl_pix1, scl_pix2, scl_out;
    logic        scl_fv, scl_hs, scl_vs, scl_de, scl_fs, scl_ls;

    // 16x8 active, 24x12 total, 2x scale, PIX_LAT=0, positive syncs
    logic [4:0]  sml_x;
    logic [3:0]  sml_y;
    logic [4:0]  sml_addr;
    logic [11:0] sml_pix, sml_out;
    logic        sml_fv, sml_hs, sml_vs, sml_de, sml_fs, sml_ls;

    vga_timing_gen u_vga (
        .clk(clk), .rst(rst), .en(en), .pixel_in(vga_pix),
        .posX(vga_x), .posY(vga_y), .fetch_valid(vga_fv), .buf_addr(vga_addr),
        .pixel_out(vga_out), .hsync(vga_hs), .vsync(vga_vs), .de(vga_de),
        .frame_start(vga_fs), .line_start(vga_ls)
    );

    vga_timing_gen #(.SCALE_SHIFT(2), .PIX_LAT(2)) u_scl (
        .clk(clk), .rst(rst), .en(en), .pixel_in(scl_pix2),
        .posX(scl_x), .posY(scl_y), .fetch_valid(scl_fv), .buf_addr(scl_addr),
        .pixel_out(scl_out), .hsync(scl_hs), .vsync(scl_vs), .de(scl_de),
        .frame_start(scl_fs), .line_start(scl_ls)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1), .VSYNC_POL(1), .SCALE_SHIFT(1), .PIX_LAT(0)
    ) u_sml (
        .clk(clk), .rst(rst), .en(en), .pixel_in(sml_pix),
        .posX(sml_x), .posY(sml_y), .fetch_valid(sml_fv), .buf_addr(sml_addr),
        .pixel_out(sml_out), .hsync(sml_hs), .vsync(sml_vs), .de(sml_de),
        .frame_start(sml_fs), .line_start(sml_ls)
    );

    // Frame-buffer models: read data returns PIX_LAT enabled cycles after the address.
    always @(posedge clk) begin
        if (en) begin
            vga_pix  <= vga_addr[11:0] + 12'd1000;
            scl_pix1 <= scl_addr[11:0];
            scl_pix2 <= scl_pix1;
        end
    end
    assign sml_pix = {7'd0, sml_addr};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int vga_de_r1, vga_de_r2, vga_hs_fall, vga_hs_lo, vga_de_hi, vga_ls_n, vga_fs_n;
    int scl_de_r1;
    int sml_de_r1, sml_vs_r1, sml_vs_hi, sml_fs_n, sml_fs_r2, sml_fs_n1, sml_hs_r1, sml_hs_hi;
    logic vga_de_p, vga_hs_p, scl_de_p, sml_de_p, sml_vs_p, sml_hs_p;
    logic [39:0] snap;
    int chg;
    logic found;

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        en  = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_posX", vga_x, 0);
        check_eq("rst_posY", vga_y, 0);
        check_eq("rst_de", vga_de, 0);
        check_eq("rst_pixel", vga_out, 0);
        check_eq("rst_hsync", vga_hs, 1);
        check_eq("rst_vsync", vga_vs, 1);
        check_eq("rst_addr", vga_addr, 0);
        check_eq("rst_fs", vga_fs, 0);
        check_eq("rst_sml_hsync", sml_hs, 0);
        check_eq("rst_sml_vsync", sml_vs, 0);

        // ---------------- free run ----------------
        rst = 1'b0;
        vga_de_r1 = -1; vga_de_r2 = -1; vga_hs_fall = -1; vga_hs_lo = 0; vga_de_hi = 0;
        vga_ls_n = 0; vga_fs_n = 0; scl_de_r1 = -1;
        sml_de_r1 = -1; sml_vs_r1 = -1; sml_vs_hi = 0; sml_fs_n = 0; sml_fs_r2 = -1;
        sml_fs_n1 = 0; sml_hs_r1 = -1; sml_hs_hi = 0;
        vga_de_p = vga_de; vga_hs_p = vga_hs; scl_de_p = scl_de;
        sml_de_p = sml_de; sml_vs_p = sml_vs; sml_hs_p = sml_hs;
        for (int k = 1; k <= 9700; k++) begin
            @(negedge clk);
            if (vga_de && !vga_de_p) begin
                if (vga_de_r1 < 0) vga_de_r1 = k;
                else if (vga_de_r2 < 0) vga_de_r2 = k;
            end
            if (!vga_hs && vga_hs_p && vga_hs_fall < 0) vga_hs_fall = k;
            if (k <= 800 && !vga_hs) vga_hs_lo++;
            if (k <= 800 && vga_de) vga_de_hi++;
            if (k <= 1600 && vga_ls) vga_ls_n++;
            if (vga_fs) vga_fs_n++;
            if (scl_de && !scl_de_p && scl_de_r1 < 0) scl_de_r1 = k;
            if (sml_de && !sml_de_p && sml_de_r1 < 0) sml_de_r1 = k;
            if (sml_vs && !sml_vs_p && sml_vs_r1 < 0) sml_vs_r1 = k;
            if (k <= 288 && sml_vs) sml_vs_hi++;
            if (sml_fs) begin
                sml_fs_n++;
                if (sml_fs_n == 2) sml_fs_r2 = k;
            end
            if (k <= 288 && sml_fs) sml_fs_n1++;
            if (sml_hs && !sml_hs_p && sml_hs_r1 < 0) sml_hs_r1 = k;
            if (k <= 24 && sml_hs) sml_hs_hi++;

            if (k == 2)    check_eq("vga_fs_at_2", vga_fs, 1);
            if (k == 102)  check_eq("vga_pix_x100", vga_out, 1100);
            if (k == 650)  check_eq("vga_pix_blank", vga_out, 0);
            if (k == 805)  check_eq("vga_pix_y1x3", vga_out, 1643);
            if (k == 78)   check_eq("sml_pix_y3x5", sml_out, 10);
            if (k == 6405) check_eq("scl_addr_y8x5", scl_addr, 321);
            if (k == 7204) check_eq("scl_addr_y9x4", scl_addr, 321);
            if (k == 7207) check_eq("scl_addr_y9x7", scl_addr, 321);
            if (k == 7208) check_eq("scl_addr_y9x8", scl_addr, 322);
            if (k == 7208) check_eq("scl_pix_y9x5", scl_out, 321);
            if (k == 8805) check_eq("scl_addr_y11x5", scl_addr, 321);
            if (k == 9605) check_eq("scl_addr_y12x5", scl_addr, 481);

            vga_de_p = vga_de; vga_hs_p = vga_hs; scl_de_p = scl_de;
            sml_de_p = sml_de; sml_vs_p = sml_vs; sml_hs_p = sml_hs;
        end
        check_eq("vga_de_first", vga_de_r1, 2);
        check_eq("vga_line_period", vga_de_r2 - vga_de_r1, 800);
        check_eq("vga_hs_fall", vga_hs_fall, 658);
        check_eq("vga_hs_width", vga_hs_lo, 96);
        check_eq("vga_de_width", vga_de_hi, 640);
        check_eq("vga_ls_count", vga_ls_n, 2);
        check_eq("vga_fs_count", vga_fs_n, 1);
        check_eq("scl_de_first", scl_de_r1, 3);
        check_eq("sml_de_first", sml_de_r1, 1);
        check_eq("sml_hs_rise", sml_hs_r1, 19);
        check_eq("sml_hs_width", sml_hs_hi, 4);
        check_eq("sml_vs_rise", sml_vs_r1, 217);
        check_eq("sml_vs_width", sml_vs_hi, 48);
        check_eq("sml_fs_per_frame", sml_fs_n1, 1);
        check_eq("sml_frame_period", sml_fs_r2, 289);

        // ---------------- en toggling ----------------
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vga_de_r1 = -1; vga_de_r2 = -1; vga_hs_fall = -1; vga_hs_lo = 0; chg = 0;
        vga_de_p = vga_de; vga_hs_p = vga_hs;
        for (int e = 1; e <= 1800; e++) begin
            en = e[0];
            snap = {vga_de, vga_hs, vga_vs, vga_fs, vga_ls, vga_out, vga_x, vga_y};
            @(negedge clk);
            if (!en && snap != {vga_de, vga_hs, vga_vs, vga_fs, vga_ls, vga_out, vga_x, vga_y}) chg++;
            if (vga_de && !vga_de_p) begin
                if (vga_de_r1 < 0) vga_de_r1 = e;
                else if (vga_de_r2 < 0) vga_de_r2 = e;
            end
            if (!vga_hs && vga_hs_p && vga_hs_fall < 0) vga_hs_fall = e;
            if (!vga_hs) vga_hs_lo++;
            vga_de_p = vga_de; vga_hs_p = vga_hs;
        end
        check_eq("en_de_first", vga_de_r1, 3);
        check_eq("en_line_period", vga_de_r2 - vga_de_r1, 1600);
        check_eq("en_hs_fall", vga_hs_fall, 1315);
        check_eq("en_hs_width", vga_hs_lo, 192);
        check_eq("en_hold_changes", chg, 0);

        // ---------------- asynchronous reset mid-line ----------------
        en = 1'b1;
        found = 1'b0;
        for (int w = 0; w < 5000 && !found; w++) begin
            @(negedge clk);
            if (vga_x == 10'd300 && vga_y == 10'd2) found = 1'b1;
        end
        check_eq("wait_pos_300_2", found, 1);
        check_eq("pre_rst_de", vga_de, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_posX", vga_x, 0);
        check_eq("async_posY", vga_y, 0);
        check_eq("async_de", vga_de, 0);
        check_eq("async_pixel", vga_out, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vga_de_r1 = -1; vga_hs_fall = -1; vga_hs_lo = 0;
        vga_de_p = vga_de; vga_hs_p = vga_hs;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            if (vga_de && !vga_de_p && vga_de_r1 < 0) vga_de_r1 = k;
            if (!vga_hs && vga_hs_p && vga_hs_fall < 0) vga_hs_fall = k;
            if (!vga_hs) vga_hs_lo++;
            vga_de_p = vga_de; vga_hs_p = vga_hs;
        end
        check_eq("rerst_de_first", vga_de_r1, 2);
        check_eq("rerst_hs_fall", vga_hs_fall, 658);
        check_eq("rerst_hs_width", vga_hs_lo, 96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
